data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Wait-stated data-memory responder that serves the pipeline MEM stage's load/store requests. It sits on the far side of the MEM stage's `MEM_R_EN` / `MEM_W_EN` / address / store-data interface. It holds a word array and answers each request after a programmable number of wait cycles. It deasserts `ready` while busy, and the top level ORs `~ready` into the pipeline freeze, so every stage holds until the access completes.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words in the array (power of two).
- `BASE_ADDR`, 1024: byte address mapped to word 0.
- `WAIT_CYCLES`, 3: cycles spent in BUSY per access (0 allowed).

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `MEM_R_EN`  in  1: load request from the MEM stage.
- `MEM_W_EN`  in  1: store request from the MEM stage.
- `addr`  in  32: byte address (ALU result).
- `wdata`  in  32: store data (Val_Rm).
- `ready`  out  1: low while an access is outstanding; the pipeline freezes on low.
- `rdata`  out  32: registered load data.
- `err`  out  1: registered one-cycle pulse marking a bad access.

## Operation
- FSM states: IDLE, BUSY, DONE. The reset state is IDLE.
- IDLE, no request: `ready` = 1.
- IDLE, request present (either enable high):
  - `ready` = 0 combinationally in the same cycle.
  - Next state is BUSY with `cnt` = WAIT_CYCLES-1. If WAIT_CYCLES = 0, next state is DONE directly.
- BUSY:
  - `ready` = 0; `cnt` decrements each cycle.
  - At `cnt` = 0, next state is DONE, and the access commits on that edge.
  - Commit for a store: writes the array. Commit for a load: loads `rdata`.
- DONE: `ready` = 1 for exactly one cycle; next state is IDLE unconditionally.
  - The request still visible in DONE is the completed one and is not restarted.
  - A request seen in the following IDLE cycle is a new access.
- Address mapping: word index = (`addr` - BASE_ADDR) >> 2, 32-bit unsigned subtraction.
  - In range when `addr` >= BASE_ADDR, `addr` < BASE_ADDR + 4*DEPTH, and `addr`[1:0] = 0.
- Out-of-range or misaligned access:
  - The store is dropped, or the load returns `rdata` = 0.
  - `err` = 1 during the DONE cycle.
- Both enables high: treated as a store, with `err` = 1 in DONE.
- `addr`, `wdata` and the enables must stay stable from the IDLE request cycle through DONE (guaranteed by the freeze). The block samples them at the commit edge.
- `rdata` holds its last loaded value until the next load commits; stores do not change it.
- Array contents are not cleared by `rst`; they are zero at simulation start.

## Timing
- Reset values: `ready` = 1 (given no request), `rdata` = 0, `err` = 0, state = IDLE, `cnt` = 0.
- Reset mid-BUSY forces IDLE immediately (asynchronous). An uncommitted store never reaches the array.
- Request first visible in cycle 0 (IDLE):
  - `ready` is low in cycles 0..WAIT_CYCLES.
  - DONE occurs in cycle WAIT_CYCLES+1 with `ready` = 1, and `rdata`/`err` are valid.
- Total occupancy per access: WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES = 0: `ready` is low in cycle 0 only, and DONE is cycle 1.
- Back-to-back accesses: at least one IDLE cycle separates DONE from the next BUSY. Minimum spacing is WAIT_CYCLES+2.
- Counter width is clog2(WAIT_CYCLES+1), minimum 1 bit.

## Test plan
- Store then load, WAIT_CYCLES = 3:
  - Store 0xDEADBEEF at 1028 -> `ready` low for 4 cycles, high 1 cycle.
  - Then load 1028 -> `rdata` = 0xDEADBEEF in DONE, `err` = 0.
- Out-of-range: load 0x00000010 and store at 1024+4*DEPTH -> `err` pulses in DONE, `rdata` = 0.
  - A subsequent load of word 0 is unchanged.
- Reset mid-operation: store 0x12345678 at 1032; assert `rst` in the 2nd BUSY cycle.
  - `ready` returns to 1 immediately.
  - A later load of 1032 returns the old value (0).
- WAIT_CYCLES = 0, back-to-back loads of 1024 and 1028 -> each `ready` low exactly 1 cycle.
  - DONE cycles are 3 apart, and correct data appears each time.
- Both enables high at 1036 with `wdata` 0xA5A5A5A5 -> `err` = 1 and the store occurs.
  - A later load returns 0xA5A5A5A5.
- Misaligned load at 1025 -> `err` = 1, `rdata` = 0, no hang (returns to IDLE).

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Wait-stated data memory sitting behind the pipeline MEM stage. It holds a
// word array and answers each load/store after WAIT_CYCLES busy cycles.
// While an access is outstanding `ready` is low, which freezes the whole
// pipeline so the request inputs stay stable until the access completes.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - asynchronous, active-high reset (array contents are kept)
//   MEM_R_EN  - load request
//   MEM_W_EN  - store request (wins when both enables are high)
//   addr      - byte address; word 0 sits at BASE_ADDR
//   wdata     - store data
//   ready     - low while an access is outstanding
//   rdata     - registered load data, held until the next load commits
//   err       - registered one-cycle pulse in DONE for a bad access
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_START = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [31:0]   ADDR_LO   = 32'(BASE_ADDR);
    localparam logic [31:0]   ADDR_HI   = 32'(BASE_ADDR + 4 * DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Contents start at zero and are deliberately untouched by rst.
    logic [31:0] mem [0:DEPTH-1] = '{default: '0};

    logic        req;
    logic        is_store;
    logic        in_range;
    logic        bad;
    logic        commit;
    logic [31:0] offset;
    logic [IW-1:0] index;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign is_store = MEM_W_EN;
    assign offset   = addr - ADDR_LO;
    assign index    = offset[IW+1:2];

    // The index alone would wrap for addresses past the top of the array,
    // so the explicit range test is what keeps those stores out of word 0.
    assign in_range = (addr >= ADDR_LO) && (addr < ADDR_HI) && (addr[1:0] == 2'b00);
    assign bad      = !in_range || (MEM_R_EN && MEM_W_EN);

    // The access commits on the edge that enters DONE: from the last BUSY
    // cycle, or straight from IDLE when there are no wait cycles.
    assign commit = ((state == BUSY) && (cnt == '0)) ||
                    ((state == IDLE) && req && (WAIT_CYCLES == 0));

    // ready drops in the same cycle a request appears so the freeze takes
    // effect before the pipeline can advance past the request.
    assign ready = !((state == BUSY) || ((state == IDLE) && req));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (commit) begin
                err <= bad;
                if (!is_store) begin
                    rdata <= in_range ? mem[index] : 32'h0;
                end
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_START;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // The request still visible here is the completed one.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Array write port; the rst gate keeps an interrupted access from
    // ever landing in the array.
    always_ff @(posedge clk) begin
        if (commit && is_store && in_range && !rst) begin
            mem[index] <= wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. Two instances are exercised: one with
// three wait cycles and one with none. A driver issues directed accesses and
// pushes the hand-computed response into a per-instance queue; a monitor
// watches for the DONE cycle (ready rising after a low stretch) and compares.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        r_en3, w_en3, ready3, err3;
    logic [31:0] addr3, wdata3, rdata3;
    logic        r_en0, w_en0, ready0, err0;
    logic [31:0] addr0, wdata0, rdata0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          low;
    } exp_t;

    exp_t q3[$];
    exp_t q0[$];

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int last_done0 = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    data_mem_responder #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en3), .MEM_W_EN(w_en3),
        .addr(addr3), .wdata(wdata3), .ready(ready3), .rdata(rdata3), .err(err3)
    );

    data_mem_responder #(.DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .MEM_R_EN(r_en0), .MEM_W_EN(w_en0),
        .addr(addr0), .wdata(wdata0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // One access: raise the request after a rising edge, hold it through
    // DONE, then drop it in the following IDLE cycle. Consecutive calls
    // leave one request-free cycle between accesses.
    task automatic apply_stimulus(input bit on3, input bit rd, input bit wr,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] exp_rdata, input bit exp_err);
        exp_t e;
        bit   seen;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.low   = on3 ? 4 : 1;
        seen    = 1'b0;
        @(posedge clk);
        #1;
        if (on3) begin
            q3.push_back(e);
            r_en3 = rd; w_en3 = wr; addr3 = a; wdata3 = d;
        end else begin
            q0.push_back(e);
            r_en0 = rd; w_en0 = wr; addr0 = a; wdata0 = d;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (on3 ? ready3 : ready0) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("done_within_budget", {31'b0, seen}, 32'd1);
        @(posedge clk);
        #1;
        if (on3) begin
            r_en3 = 1'b0; w_en3 = 1'b0;
        end else begin
            r_en0 = 1'b0; w_en0 = 1'b0;
        end
    endtask

    // Monitor: index 1 is the three-wait instance, index 0 the zero-wait one.
    initial begin : monitor
        int   low_cnt [2];
        bit   was_low [2];
        exp_t e;
        logic rdy;
        logic er;
        logic [31:0] rd;
        string tag;
        low_cnt = '{0, 0};
        was_low = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rdy = (k == 1) ? ready3 : ready0;
                er  = (k == 1) ? err3 : err0;
                rd  = (k == 1) ? rdata3 : rdata0;
                tag = (k == 1) ? "u3" : "u0";
                if (rst) begin
                    low_cnt[k] = 0;
                    was_low[k] = 1'b0;
                end else if (!rdy) begin
                    low_cnt[k]++;
                    was_low[k] = 1'b1;
                    check_output({tag, "_err_while_busy"}, {31'b0, er}, 32'd0);
                end else if (was_low[k]) begin
                    if ((k == 1) ? (q3.size() == 0) : (q0.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL %s_unexpected_done: got a DONE cycle expected none (cycle %0d)", tag, cycle);
                    end else begin
                        if (k == 1) e = q3.pop_front();
                        else        e = q0.pop_front();
                        check_output({tag, "_rdata"}, rd, e.rdata);
                        check_output({tag, "_err"}, {31'b0, er}, {31'b0, e.err});
                        check_output({tag, "_ready_low_cycles"}, 32'(low_cnt[k]), 32'(e.low));
                    end
                    if (k == 0) last_done0 = cycle;
                    was_low[k] = 1'b0;
                    low_cnt[k] = 0;
                end else begin
                    check_output({tag, "_err_idle"}, {31'b0, er}, 32'd0);
                end
            end
        end
    end

    initial begin : main
        int t1;
        rst = 1'b1;
        r_en3 = 1'b0; w_en3 = 1'b0; addr3 = '0; wdata3 = '0;
        r_en0 = 1'b0; w_en0 = 1'b0; addr0 = '0; wdata0 = '0;

        // Reset state
        @(negedge clk);
        check_output("u3_reset_ready", {31'b0, ready3}, 32'd1);
        check_output("u3_reset_rdata", rdata3, 32'h0);
        check_output("u3_reset_err", {31'b0, err3}, 32'd0);
        check_output("u0_reset_ready", {31'b0, ready0}, 32'd1);
        check_output("u0_reset_rdata", rdata0, 32'h0);
        check_output("u0_reset_err", {31'b0, err0}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Store then load with three wait cycles
        apply_stimulus(1, 0, 1, 32'd1028, 32'hDEADBEEF, 32'h0, 0);
        apply_stimulus(1, 1, 0, 32'd1028, 32'h0, 32'hDEADBEEF, 0);
        // Store to word 0; rdata keeps the last load
        apply_stimulus(1, 0, 1, 32'd1024, 32'h11110000, 32'hDEADBEEF, 0);
        // Out-of-range load and store (1280 would alias word 0 if unguarded)
        apply_stimulus(1, 1, 0, 32'h00000010, 32'h0, 32'h0, 1);
        apply_stimulus(1, 0, 1, 32'd1280, 32'h99999999, 32'h0, 1);
        apply_stimulus(1, 1, 0, 32'd1024, 32'h0, 32'h11110000, 0);

        // Reset during the second BUSY cycle of a store to 1032
        @(posedge clk);
        #1;
        w_en3 = 1'b1; addr3 = 32'd1032; wdata3 = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        w_en3 = 1'b0;
        #1;
        check_output("u3_ready_on_reset", {31'b0, ready3}, 32'd1);
        check_output("u3_rdata_on_reset", rdata3, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(1, 1, 0, 32'd1032, 32'h0, 32'h0, 0);

        // Both enables: a store with err flagged
        apply_stimulus(1, 1, 1, 32'd1036, 32'hA5A5A5A5, 32'h0, 1);
        apply_stimulus(1, 1, 0, 32'd1036, 32'h0, 32'hA5A5A5A5, 0);

        // Misaligned load, then a normal load to show the FSM recovered
        apply_stimulus(1, 1, 0, 32'd1025, 32'h0, 32'h0, 1);
        apply_stimulus(1, 1, 0, 32'd1028, 32'h0, 32'hDEADBEEF, 0);

        // Zero wait cycles: fill two words, then loads one bubble apart
        apply_stimulus(0, 0, 1, 32'd1024, 32'h0BADF00D, 32'h0, 0);
        apply_stimulus(0, 0, 1, 32'd1028, 32'hCAFEBABE, 32'h0, 0);
        apply_stimulus(0, 1, 0, 32'd1024, 32'h0, 32'h0BADF00D, 0);
        t1 = last_done0;
        apply_stimulus(0, 1, 0, 32'd1028, 32'h0, 32'hCAFEBABE, 0);
        check_output("u0_done_spacing", 32'(last_done0 - t1), 32'd3);

        repeat (3) @(posedge clk);
        check_output("u3_queue_drained", 32'(q3.size()), 32'd0);
        check_output("u0_queue_drained", 32'(q0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
